// File: rtl/ucsbece154b_fifo_fwft_if.sv
// rtl/ucsbece154b_fifo_fwft_if.sv - Handshake/bus bundle for the first-word-fall-through FIFO
interface ucsbece154b_fifo_fwft_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NR_ENTRIES = 4
) ();
    logic                          flush_i;
    logic [DATA_WIDTH-1:0]         data_i;
    logic                          push_i;
    logic                          pop_i;
    logic [DATA_WIDTH-1:0]         data_o;
    logic                          valid_o;
    logic                          full_o;
    logic                          almost_full_o;
    logic [$clog2(NR_ENTRIES):0]   count_o;
    logic                          overflow_o;
    logic                          underflow_o;

    modport master (
        output flush_i, data_i, push_i, pop_i,
        input  data_o, valid_o, full_o, almost_full_o, count_o, overflow_o, underflow_o
    );

    modport slave (
        input  flush_i, data_i, push_i, pop_i,
        output data_o, valid_o, full_o, almost_full_o, count_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/ucsbece154b_fifo_fwft.sv
// rtl/ucsbece154b_fifo_fwft.sv - FWFT FIFO with occupancy, almost-full and optional sticky error flags (UCSBECE154B_FIFO_ERR_FLAGS_EN)
module ucsbece154b_fifo_fwft #(
    parameter int DATA_WIDTH = 32,
    parameter int NR_ENTRIES = 4,
    parameter int AF_THRESH  = NR_ENTRIES - 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    ucsbece154b_fifo_fwft_if.slave    bus
);
    localparam int PW = $clog2(NR_ENTRIES);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] mem_q [NR_ENTRIES];
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  valid, full;
    logic                  push_acc, pop_acc;

    // Status comes only from the registered count, so no input reaches these outputs.
    assign valid = (count_q != '0);
    assign full  = (count_q == CW'(NR_ENTRIES));

    // A push into a full FIFO is still taken when the head leaves in the same cycle.
    assign pop_acc  = bus.pop_i & valid;
    assign push_acc = bus.push_i & (~full | pop_acc);

    assign bus.valid_o       = valid;
    assign bus.full_o        = full;
    assign bus.almost_full_o = (count_q >= CW'(AF_THRESH));
    assign bus.count_o       = count_q;
    assign bus.data_o        = valid ? mem_q[head_q] : '0;

    // Next pointers and occupancy; flush overrides any push or pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_acc) tail_d = tail_q + PW'(1);
            if (pop_acc)  head_d = head_q + PW'(1);
            if (push_acc && !pop_acc)      count_d = count_q + CW'(1);
            else if (pop_acc && !push_acc) count_d = count_q - CW'(1);
        end
    end

    // Pointer and count registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage write at the tail; contents are never cleared, validity is tracked by count.
    always_ff @(posedge clk_i) begin
        if (push_acc && !bus.flush_i) mem_q[tail_q] <= bus.data_i;
    end

`ifdef UCSBECE154B_FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // Sticky error flags, cleared only by flush or reset.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (bus.flush_i) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            if (bus.push_i && full && !pop_acc) ovf_d = 1'b1;
            if (bus.pop_i && !valid)            unf_d = 1'b1;
        end
    end

    // Error flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.overflow_o  = ovf_q;
    assign bus.underflow_o = unf_q;
`else
    assign bus.overflow_o  = 1'b0;
    assign bus.underflow_o = 1'b0;
`endif
endmodule

// File: tb/tb_ucsbece154b_fifo_fwft.sv
// tb/tb_ucsbece154b_fifo_fwft.sv - Self-checking bench for the FWFT FIFO
module tb_ucsbece154b_fifo_fwft;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    logic [31:0] model_q [$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    always #5 clk = ~clk;

    ucsbece154b_fifo_fwft_if #(.DATA_WIDTH(32), .NR_ENTRIES(4)) bus ();

    ucsbece154b_fifo_fwft #(.DATA_WIDTH(32), .NR_ENTRIES(4), .AF_THRESH(3)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic        push;
        logic        pop;
        logic        flush;
        logic [31:0] data;
        int          cnt;
        logic        valid;
        logic        full;
        logic        af;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] model_head();
        return (model_q.size() != 0) ? model_q[0] : 32'h0;
    endfunction

    // Called at a falling edge: drive inputs, score any accepted pop, update model, advance one cycle.
    task automatic drive(input logic pu, input logic po, input logic fl, input logic [31:0] d);
        logic m_pop, m_push;
        logic [31:0] e;
        bus.push_i  = pu;
        bus.pop_i   = po;
        bus.flush_i = fl;
        bus.data_i  = d;
        m_pop  = po && (model_q.size() != 0);
        m_push = pu && ((model_q.size() < 4) || m_pop);
        if (fl) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
`ifdef UCSBECE154B_FIFO_ERR_FLAGS_EN
            if (pu && model_q.size() == 4 && !m_pop) m_ovf = 1'b1;
            if (po && model_q.size() == 0)           m_unf = 1'b1;
`endif
            if (m_pop) begin
                e = model_q.pop_front();
                check("pop_data", bus.data_o, e);
            end
            if (m_push) model_q.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
        bus.push_i  = 1'b0;
        bus.pop_i   = 1'b0;
        bus.flush_i = 1'b0;
    endtask

    task automatic check_flags();
        check("overflow", {31'b0, bus.overflow_o}, {31'b0, m_ovf});
        check("underflow", {31'b0, bus.underflow_o}, {31'b0, m_unf});
    endtask

    vec_t vecs [14];

    initial begin
        bus.push_i  = 1'b0;
        bus.pop_i   = 1'b0;
        bus.flush_i = 1'b0;
        bus.data_i  = '0;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h11, 1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h22, 2, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h33, 3, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h44, 4, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'hEE, 4, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,  3, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,  2, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,  0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,  0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h77, 1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,  0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 32'hA5, 1, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h01, 0, 1'b0, 1'b0, 1'b0};

        // Reset state while rst_n is held low.
        #1;
        check("rst_count", 32'(bus.count_o), 32'd0);
        check("rst_valid", {31'b0, bus.valid_o}, 32'd0);
        check("rst_full", {31'b0, bus.full_o}, 32'd0);
        check("rst_af", {31'b0, bus.almost_full_o}, 32'd0);
        check("rst_data", bus.data_o, 32'd0);
        check_flags();
        @(negedge clk);
        rst_n = 1'b1;

        // Table: fill, overflow attempt, drain, underflow attempt, empty push+pop, FWFT, flush priority.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].push, vecs[i].pop, vecs[i].flush, vecs[i].data);
            check($sformatf("v%0d_count", i), 32'(bus.count_o), 32'(vecs[i].cnt));
            check($sformatf("v%0d_valid", i), {31'b0, bus.valid_o}, {31'b0, vecs[i].valid});
            check($sformatf("v%0d_full", i), {31'b0, bus.full_o}, {31'b0, vecs[i].full});
            check($sformatf("v%0d_af", i), {31'b0, bus.almost_full_o}, {31'b0, vecs[i].af});
            check($sformatf("v%0d_data", i), bus.data_o, model_head());
            check_flags();
        end

        // FWFT latency with no pop issued.
        drive(1'b1, 1'b0, 1'b0, 32'hA5);
        check("fwft_valid", {31'b0, bus.valid_o}, 32'd1);
        check("fwft_data", bus.data_o, 32'hA5);
        drive(1'b0, 1'b1, 1'b0, 32'h0);

        // Fill, then simultaneous push+pop while full across the pointer wrap.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 32'h100 + i);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h5500 + i);
            check("bypass_count", 32'(bus.count_o), 32'd4);
            check("bypass_full", {31'b0, bus.full_o}, 32'd1);
        end
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("drain_valid", {31'b0, bus.valid_o}, 32'd0);
        check("drain_data", bus.data_o, 32'd0);
        check_flags();

`ifdef UCSBECE154B_FIFO_ERR_FLAGS_EN
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 32'h200 + i);
        drive(1'b1, 1'b0, 1'b0, 32'hBAD);
        check("err_ovf", {31'b0, bus.overflow_o}, 32'd1);
        check("err_count", 32'(bus.count_o), 32'd4);
        drive(1'b0, 1'b0, 1'b1, 32'h0);
        check("err_flush_count", 32'(bus.count_o), 32'd0);
        check("err_flush_ovf", {31'b0, bus.overflow_o}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("err_unf", {31'b0, bus.underflow_o}, 32'd1);
        drive(1'b0, 1'b0, 1'b1, 32'h0);
`endif

        // Async reset between edges with three entries stored.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 32'h300 + i);
        check("pre_rst_count", 32'(bus.count_o), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", 32'(bus.count_o), 32'd0);
        check("arst_valid", {31'b0, bus.valid_o}, 32'd0);
        check("arst_full", {31'b0, bus.full_o}, 32'd0);
        check("arst_af", {31'b0, bus.almost_full_o}, 32'd0);
        check("arst_data", bus.data_o, 32'd0);
        model_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check_flags();
        #1 rst_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h99);
        check("post_rst_data", bus.data_o, 32'h99);
        check("post_rst_count", 32'(bus.count_o), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("post_rst_empty", {31'b0, bus.valid_o}, 32'd0);
        check("sb_empty", 32'(model_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
